tx_srcmux: RTL and testbench
============================

TX_SRCMUX -- requirements
Module: tx_srcmux

Interface
REQ-001 The block SHALL have parameter NSRC, default 4, number of transmit bit sources (2..8).
REQ-002 The block SHALL have parameter SELW, default 2, width of the source select (ceil(log2(NSRC)), min 1).
REQ-003 The block SHALL have parameter CNTW, default 10, width of the transmitted-bit counter.
REQ-004 The block SHALL have parameter MAXBITS, default 10'd600, bit limit before a forced done.
REQ-005 The block SHALL have port clk, input, 1, system oscillator clock; all logic on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, asynchronous active-high master reset.
REQ-007 The block SHALL have port sel_in, input, SELW, requested source index.
REQ-008 The block SHALL have port sel_load, input, 1, single-cycle strobe to latch sel_in.
REQ-009 The block SHALL have port tx_abort, input, 1, level; returns the block to IDLE.
REQ-010 The block SHALL have port txbitstb, input, 1, single-cycle bit request strobe from the sequencer.
REQ-011 The block SHALL have port srcbit, input, NSRC, current data bit of each source (msb first).
REQ-012 The block SHALL have port srcdone, input, NSRC, per-source last-bit-consumed flags.
REQ-013 The block SHALL have port srcbitstb, output, NSRC, one-hot gated bit strobe to the selected source.
REQ-014 The block SHALL have port txbitsrc, output, 1, selected source data bit.
REQ-015 The block SHALL have port txdatadone, output, 1, registered sticky done to the sequencer.
REQ-016 The block SHALL have port bitcount, output, CNTW, strobes forwarded in the current transmission.
REQ-017 The block SHALL have port sel_err, output, 1, sticky flag: sel_load with sel_in >= NSRC.
REQ-018 The block SHALL have port overrun, output, 1, sticky flag: MAXBITS reached without srcdone.

Function
REQ-019 The block SHALL implement states IDLE, ARMED, STREAM, DONE, held in a registered state vector.
REQ-020 In IDLE, sel_load with sel_in < NSRC SHALL latch sel_q <= sel_in, clear bitcount, and enter ARMED next cycle.
REQ-021 In IDLE, sel_load with sel_in >= NSRC SHALL set sel_err, leave sel_q unchanged, and stay in IDLE.
REQ-022 The block SHALL ignore sel_load outside IDLE; sel_q is frozen for the whole transmission.
REQ-023 In ARMED, the first txbitstb SHALL enter STREAM; the strobe itself is forwarded and counted.
REQ-024 srcbitstb[i] SHALL equal txbitstb & (sel_q==i) & (state is ARMED or STREAM), combinationally, zero latency.
REQ-025 txbitsrc SHALL equal srcbit[sel_q] in ARMED/STREAM/DONE and 0 in IDLE, combinationally.
REQ-026 bitcount SHALL increment by 1 per forwarded strobe and saturate at all-ones.
REQ-027 In ARMED or STREAM, srcdone[sel_q] high SHALL enter DONE and set txdatadone at the next edge.
REQ-028 A strobe coincident with srcdone[sel_q] SHALL still be forwarded and counted before DONE.
REQ-029 In DONE, srcbitstb SHALL be all zero, txdatadone SHALL stay 1, and bitcount SHALL hold.
REQ-030 tx_abort SHALL force IDLE, clear txdatadone, and zero srcbitstb from any state; it wins over sel_load, txbitstb and srcdone in the same cycle.
REQ-031 sel_err and overrun SHALL clear only on reset or on a valid sel_load.
REQ-032 srcdone of non-selected sources SHALL have no effect.

Reset
REQ-033 Reset SHALL asynchronously force state=IDLE, sel_q=0, bitcount=0, txdatadone=0, sel_err=0, overrun=0.
REQ-034 While reset is high, srcbitstb SHALL be 0 and txbitsrc SHALL be 0, including reset mid-STREAM.

Configuration
REQ-035 With macro TXSRC_BITLIMIT_EN defined, bitcount reaching MAXBITS in STREAM without srcdone[sel_q] SHALL set overrun and txdatadone and enter DONE on the same edge.
REQ-036 Without TXSRC_BITLIMIT_EN, there is no limit check, overrun is tied 0, and bitcount still counts and saturates.

Verification
REQ-037 NSRC=4: sel_in=2 with sel_load, 8 strobes, srcdone[2] on the 8th -> srcbitstb=4'b0100 per strobe, bitcount=8, txdatadone=1 next cycle.
REQ-038 NSRC=3: sel_load with sel_in=3 -> sel_err=1, state IDLE, srcbitstb stays 0 under strobes.
REQ-039 Mid-STREAM: tx_abort and sel_load(sel_in=1) in the same cycle -> IDLE, txdatadone=0, sel_q unchanged; a later valid sel_load arms normally.
REQ-040 TXSRC_BITLIMIT_EN, MAXBITS=16: 20 strobes, srcdone low -> overrun=1, txdatadone=1 at bitcount=16, strobes 17-20 not forwarded.
REQ-041 Reset asserted mid-STREAM at bitcount=5 -> all outputs 0 immediately, IDLE after release.
REQ-042 srcdone[0] pulse while sel_q=3 -> no state change; txbitsrc tracks srcbit[3] toggles.

Source files
------------

// File: rtl/tx_srcmux.sv
// Transmit bit-source multiplexer: forwards sequencer bit strobes to one latched source, returns its data bit and done flag.
// Optional bit limit enabled by `define TXSRC_BITLIMIT_EN (forces DONE with overrun at MAXBITS).
module tx_srcmux #(
    parameter int              NSRC    = 4,
    parameter int              SELW    = 2,
    parameter int              CNTW    = 10,
    parameter logic [CNTW-1:0] MAXBITS = 10'd600
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [SELW-1:0] sel_in,
    input  logic            sel_load,
    input  logic            tx_abort,
    input  logic            txbitstb,
    input  logic [NSRC-1:0] srcbit,
    input  logic [NSRC-1:0] srcdone,
    output logic [NSRC-1:0] srcbitstb,
    output logic            txbitsrc,
    output logic            txdatadone,
    output logic [CNTW-1:0] bitcount,
    output logic            sel_err,
    output logic            overrun
);

    typedef enum logic [1:0] {IDLE, ARMED, STREAM, DONE} state_t;

    state_t          state, state_nxt;
    logic [SELW-1:0] sel_q, sel_q_nxt;
    logic [CNTW-1:0] cnt_q, cnt_nxt, cnt_inc;
    logic            done_q, done_nxt;
    logic            err_q, err_nxt;
    logic            ovr_q, ovr_nxt;
    logic            sel_ok, done_sel, bit_sel, fwd, limit_hit;

    // Per-source lookup by loop so a non-power-of-two NSRC never indexes past the vector.
    always_comb begin
        done_sel = 1'b0;
        bit_sel  = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (sel_q == SELW'(i)) begin
                done_sel = srcdone[i];
                bit_sel  = srcbit[i];
            end
        end
    end

    assign sel_ok  = int'({1'b0, sel_in}) < NSRC;
    assign fwd     = txbitstb && !tx_abort && !reset && (state == ARMED || state == STREAM);
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNTW'(1);

    always_comb begin
        srcbitstb = '0;
        for (int i = 0; i < NSRC; i++) begin
            srcbitstb[i] = fwd && (sel_q == SELW'(i));
        end
    end

    assign txbitsrc = bit_sel && (state != IDLE) && !reset;

`ifdef TXSRC_BITLIMIT_EN
    // srcdone on the same strobe takes priority, so a source ending exactly at the limit is not an overrun.
    assign limit_hit = fwd && !done_sel && (cnt_inc == MAXBITS);
`else
    // No limit: overrun register can never set and collapses to a constant 0.
    logic unused_maxbits;
    assign unused_maxbits = ^MAXBITS;
    assign limit_hit      = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        sel_q_nxt = sel_q;
        cnt_nxt   = fwd ? cnt_inc : cnt_q;
        done_nxt  = done_q;
        err_nxt   = err_q;
        ovr_nxt   = ovr_q;
        if (tx_abort) begin
            state_nxt = IDLE;
            done_nxt  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_load) begin
                        if (sel_ok) begin
                            sel_q_nxt = sel_in;
                            cnt_nxt   = '0;
                            done_nxt  = 1'b0;
                            err_nxt   = 1'b0;
                            ovr_nxt   = 1'b0;
                            state_nxt = ARMED;
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end
                end
                ARMED, STREAM: begin
                    if (done_sel) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end else if (limit_hit) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                        ovr_nxt   = 1'b1;
                    end else if (txbitstb) begin
                        state_nxt = STREAM;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            sel_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            sel_q  <= sel_q_nxt;
            cnt_q  <= cnt_nxt;
            done_q <= done_nxt;
            err_q  <= err_nxt;
            ovr_q  <= ovr_nxt;
        end
    end

    assign bitcount   = cnt_q;
    assign txdatadone = done_q;
    assign sel_err    = err_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_tx_srcmux.sv
// Directed bench for tx_srcmux: one NSRC=4 instance (MAXBITS=16) and one NSRC=3 instance for select-range errors.
module tb_tx_srcmux;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] sel_in;
    logic       sel_load;
    logic       tx_abort;
    logic       txbitstb;
    logic [3:0] srcbit;
    logic [3:0] srcdone;
    logic [3:0] srcbitstb;
    logic       txbitsrc, txdatadone, sel_err, overrun;
    logic [9:0] bitcount;

    logic [1:0] b_sel_in;
    logic       b_sel_load;
    logic [2:0] b_srcbit, b_srcdone, b_srcbitstb;
    logic       b_txbitsrc, b_txdatadone, b_sel_err, b_overrun;
    logic [9:0] b_bitcount;

    logic [3:0] exp_q[$];
    int npass = 0;
    int ntot  = 0;

    always #5 clk = ~clk;

    tx_srcmux #(.NSRC(4), .SELW(2), .CNTW(10), .MAXBITS(10'd16)) u0 (
        .clk(clk), .reset(reset), .sel_in(sel_in), .sel_load(sel_load),
        .tx_abort(tx_abort), .txbitstb(txbitstb), .srcbit(srcbit), .srcdone(srcdone),
        .srcbitstb(srcbitstb), .txbitsrc(txbitsrc), .txdatadone(txdatadone),
        .bitcount(bitcount), .sel_err(sel_err), .overrun(overrun)
    );

    tx_srcmux #(.NSRC(3), .SELW(2), .CNTW(10), .MAXBITS(10'd16)) u1 (
        .clk(clk), .reset(reset), .sel_in(b_sel_in), .sel_load(b_sel_load),
        .tx_abort(tx_abort), .txbitstb(txbitstb), .srcbit(b_srcbit), .srcdone(b_srcdone),
        .srcbitstb(b_srcbitstb), .txbitsrc(b_txbitsrc), .txdatadone(b_txdatadone),
        .bitcount(b_bitcount), .sel_err(b_sel_err), .overrun(b_overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One strobe on the u0 side; expected one-hot pushed at drive time, popped when the DUT output is sampled.
    task automatic strobe(input logic [3:0] exp_vec, input logic [3:0] done_vec);
        @(negedge clk);
        txbitstb = 1'b1;
        srcdone  = done_vec;
        exp_q.push_back(exp_vec);
        #1;
        chk("srcbitstb", {28'd0, srcbitstb}, {28'd0, exp_q.pop_front()});
        @(negedge clk);
        txbitstb = 1'b0;
        srcdone  = 4'b0000;
        #1;
    endtask

    task automatic load(input logic [1:0] v);
        @(negedge clk);
        sel_in   = v;
        sel_load = 1'b1;
        @(negedge clk);
        sel_load = 1'b0;
        #1;
    endtask

    task automatic abort_pulse();
        @(negedge clk);
        tx_abort = 1'b1;
        @(negedge clk);
        tx_abort = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1; sel_in = 2'd0; sel_load = 1'b0; tx_abort = 1'b0; txbitstb = 1'b0;
        srcbit = 4'hF; srcdone = 4'h0;
        b_sel_in = 2'd0; b_sel_load = 1'b0; b_srcbit = 3'b111; b_srcdone = 3'b000;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_bitcount", 32'(bitcount), 32'd0);
        chk("rst_done", 32'(txdatadone), 32'd0);
        chk("rst_sel_err", 32'(sel_err), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_txbitsrc", 32'(txbitsrc), 32'd0);
        chk("rst_srcbitstb", 32'(srcbitstb), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Source 2, eight strobes, srcdone[2] with the last one
        srcbit = 4'b0100;
        load(2'd2);
        chk("arm_bitcount", 32'(bitcount), 32'd0);
        chk("arm_txbitsrc", 32'(txbitsrc), 32'd1);
        for (int i = 0; i < 7; i++) strobe(4'b0100, 4'b0000);
        chk("pre_done", 32'(txdatadone), 32'd0);
        chk("cnt7", 32'(bitcount), 32'd7);
        strobe(4'b0100, 4'b0100);
        chk("done_set", 32'(txdatadone), 32'd1);
        chk("cnt8", 32'(bitcount), 32'd8);
        strobe(4'b0000, 4'b0000);
        chk("done_hold_cnt", 32'(bitcount), 32'd8);
        chk("done_sticky", 32'(txdatadone), 32'd1);
        abort_pulse();
        chk("abort_clr_done", 32'(txdatadone), 32'd0);

        // Abort together with sel_load mid-stream: load must be ignored
        srcbit = 4'b0000;
        load(2'd3);
        chk("arm3_bitcount", 32'(bitcount), 32'd0);
        for (int i = 0; i < 3; i++) strobe(4'b1000, 4'b0000);
        @(negedge clk);
        tx_abort = 1'b1; sel_load = 1'b1; sel_in = 2'd1; txbitstb = 1'b1;
        #1;
        chk("abort_gates_stb", 32'(srcbitstb), 32'd0);
        @(negedge clk);
        tx_abort = 1'b0; sel_load = 1'b0; txbitstb = 1'b0;
        #1;
        chk("abort_load_done", 32'(txdatadone), 32'd0);
        chk("abort_load_cnt", 32'(bitcount), 32'd3);
        strobe(4'b0000, 4'b0000);
        load(2'd1);
        chk("rearm_cnt", 32'(bitcount), 32'd0);
        strobe(4'b0010, 4'b0000);
        chk("rearm_cnt1", 32'(bitcount), 32'd1);

        // Non-selected srcdone ignored; txbitsrc follows srcbit[3]
        abort_pulse();
        load(2'd3);
        @(negedge clk);
        srcdone = 4'b0001;
        @(negedge clk);
        srcdone = 4'b0000;
        #1;
        chk("nonsel_done", 32'(txdatadone), 32'd0);
        strobe(4'b1000, 4'b0000);
        @(negedge clk);
        srcbit = 4'b1000;
        #1;
        chk("bit3_hi", 32'(txbitsrc), 32'd1);
        srcbit = 4'b0111;
        #1;
        chk("bit3_lo", 32'(txbitsrc), 32'd0);

        // Reset mid-stream at bitcount 5
        for (int i = 0; i < 4; i++) strobe(4'b1000, 4'b0000);
        chk("cnt5", 32'(bitcount), 32'd5);
        @(negedge clk);
        srcbit = 4'b1000; txbitstb = 1'b1; reset = 1'b1;
        #1;
        chk("mid_rst_stb", 32'(srcbitstb), 32'd0);
        chk("mid_rst_bit", 32'(txbitsrc), 32'd0);
        chk("mid_rst_cnt", 32'(bitcount), 32'd0);
        chk("mid_rst_done", 32'(txdatadone), 32'd0);
        @(negedge clk);
        reset = 1'b0; txbitstb = 1'b0;
        strobe(4'b0000, 4'b0000);

        // Bit limit behaviour on 20 strobes, srcdone low
        load(2'd0);
        for (int i = 0; i < 20; i++) begin
`ifdef TXSRC_BITLIMIT_EN
            strobe((i < 16) ? 4'b0001 : 4'b0000, 4'b0000);
`else
            strobe(4'b0001, 4'b0000);
`endif
        end
`ifdef TXSRC_BITLIMIT_EN
        chk("limit_cnt", 32'(bitcount), 32'd16);
        chk("limit_overrun", 32'(overrun), 32'd1);
        chk("limit_done", 32'(txdatadone), 32'd1);
`else
        chk("nolimit_cnt", 32'(bitcount), 32'd20);
        chk("nolimit_overrun", 32'(overrun), 32'd0);
        chk("nolimit_done", 32'(txdatadone), 32'd0);
`endif
        abort_pulse();
        load(2'd0);
        chk("load_clr_overrun", 32'(overrun), 32'd0);
        abort_pulse();

        // NSRC=3 instance: out-of-range select
        @(negedge clk);
        b_sel_in = 2'd3; b_sel_load = 1'b1;
        @(negedge clk);
        b_sel_load = 1'b0;
        #1;
        chk("b_sel_err", 32'(b_sel_err), 32'd1);
        @(negedge clk);
        txbitstb = 1'b1;
        #1;
        chk("b_err_stb", 32'(b_srcbitstb), 32'd0);
        chk("b_err_bit", 32'(b_txbitsrc), 32'd0);
        @(negedge clk);
        txbitstb = 1'b0;
        b_sel_in = 2'd2; b_sel_load = 1'b1;
        @(negedge clk);
        b_sel_load = 1'b0;
        #1;
        chk("b_err_clr", 32'(b_sel_err), 32'd0);
        @(negedge clk);
        txbitstb = 1'b1;
        #1;
        chk("b_valid_stb", 32'(b_srcbitstb), 32'd4);
        @(negedge clk);
        txbitstb = 1'b0;
        #1;
        chk("b_valid_cnt", 32'(b_bitcount), 32'd1);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
